// File: rtl/cpu_types_pkg.sv
// Shared types for the hardware TLB refill walker: PTE and TLB entry layouts,
// walker states, fault causes and TLB register-port offsets.
package cpu_types_pkg;

  localparam logic [31:0] TLB_LO     = 32'h0000_0000;
  localparam logic [31:0] TLB_HI     = 32'h0000_0008;
  localparam logic [31:0] TLB_CTL    = 32'h0000_0020;
  localparam logic [31:0] CTL_COMMIT = 32'h8000_0000;

  // Valid bit sits in bit 0 of the 64-bit page-table entry
  typedef struct packed {
    logic [51:0] ppn;
    logic [10:0] attr;
    logic        v;
  } pte_t;

  // Low word is the raw PTE, high word carries {rsvd, asid, vpn}
  typedef struct packed {
    logic [15:0] rsvd;
    logic [15:0] asid;
    logic [31:0] vpn;
    pte_t        pte;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PT_RD,
    ST_CHK,
    ST_WR_LO,
    ST_WR_HI,
    ST_WR_CTL,
    ST_DONE,
    ST_FAULT
  } refill_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_PTE_INV = 2'd1,
    CAUSE_BUS_ERR = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } fault_cause_t;

endpackage

// File: rtl/tlb_refill_timeout.sv
// Bus ack watchdog: reloads while no strobe is out, counts down while one is,
// and flags expiry on the last allowed strobe cycle that saw no ack.
module tlb_refill_timeout #(
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TO_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(TO_CYCLES);
    end else if (load) begin
      cnt_q <= CNT_W'(TO_CYCLES);
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_c = run && (cnt_q == '0);

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB miss walker: reads one PTE from a flat page table and, when valid,
// programs lo/hi/commit registers of the TLB with a round-robin way.
module tlb_refill_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LOG_PAGESIZE = 13,
  parameter int unsigned WAYS         = 4,
  parameter int unsigned TO_CYCLES    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [31:0] ptbr_i,
  input  logic        miss_i,
  input  logic [31:0] miss_adr_i,
  input  logic [15:0] miss_asid_i,
  input  logic [7:0]  miss_id_i,
  output logic        missack_o,
  output logic        pt_cyc_o,
  output logic        pt_stb_o,
  output logic [31:0] pt_adr_o,
  input  logic [63:0] pt_dat_i,
  input  logic        pt_ack_i,
  input  logic        pt_err_i,
  output logic        tlb_cs_o,
  output logic        tlb_cyc_o,
  output logic        tlb_stb_o,
  output logic        tlb_we_o,
  output logic [7:0]  tlb_sel_o,
  output logic [31:0] tlb_adr_o,
  output logic [63:0] tlb_dat_o,
  input  logic        tlb_ack_i,
  output logic        upd_busy_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fault_adr_o,
  output logic [7:0]  fault_id_o,
  input  logic        fault_ack_i
);

  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  refill_state_t    state_q;
  logic [31:0]      adr_q;
  logic [15:0]      asid_q;
  logic [7:0]       id_q;
  pte_t             pte_q;
  logic [WAY_W-1:0] way_q;
  logic             pt_req_q;
  logic             tlb_req_q;
  logic             to_expire_c;
  tlb_entry_t       entry_c;
  logic [63:0]      ctl_word_c;

  assign pt_cyc_o  = pt_req_q;
  assign pt_stb_o  = pt_req_q;
  assign tlb_cs_o  = tlb_req_q;
  assign tlb_cyc_o = tlb_req_q;
  assign tlb_stb_o = tlb_req_q;
  assign tlb_we_o  = tlb_req_q;
  assign tlb_sel_o = {8{tlb_req_q}};

  // Every strobe is preceded by at least one quiet clock, so the watchdog reloads per strobe
  tlb_refill_timeout #(.TO_CYCLES(TO_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (!(pt_req_q || tlb_req_q)),
    .run      (pt_req_q || tlb_req_q),
    .expire_c (to_expire_c)
  );

  always_comb begin
    entry_c      = '0;
    entry_c.vpn  = 32'(adr_q >> (LOG_PAGESIZE + 9));
    entry_c.asid = asid_q;
    entry_c.pte  = pte_q;
  end

  assign ctl_word_c = 64'(CTL_COMMIT | (32'(way_q) << 16) |
                          ((adr_q >> LOG_PAGESIZE) & 32'h0000_FFFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      adr_q         <= '0;
      asid_q        <= '0;
      id_q          <= '0;
      pte_q         <= '0;
      way_q         <= '0;
      missack_o     <= 1'b0;
      pt_req_q      <= 1'b0;
      pt_adr_o      <= '0;
      tlb_req_q     <= 1'b0;
      tlb_adr_o     <= '0;
      tlb_dat_o     <= '0;
      upd_busy_o    <= 1'b0;
      fault_o       <= 1'b0;
      fault_cause_o <= CAUSE_NONE;
      fault_adr_o   <= '0;
      fault_id_o    <= '0;
    end else begin
      missack_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (miss_i && en_i && !fault_o) begin
            adr_q     <= miss_adr_i;
            asid_q    <= miss_asid_i;
            id_q      <= miss_id_i;
            missack_o <= 1'b1;
            pt_req_q  <= 1'b1;
            pt_adr_o  <= ptbr_i + ((miss_adr_i >> LOG_PAGESIZE) << 3);
            state_q   <= ST_PT_RD;
          end
        end
        ST_PT_RD: begin
          if (pt_ack_i) begin
            pte_q    <= pte_t'(pt_dat_i);
            pt_req_q <= 1'b0;
            state_q  <= ST_CHK;
          end else if (pt_err_i || to_expire_c) begin
            pt_req_q      <= 1'b0;
            fault_o       <= 1'b1;
            fault_cause_o <= pt_err_i ? CAUSE_BUS_ERR : CAUSE_TIMEOUT;
            fault_adr_o   <= adr_q;
            fault_id_o    <= id_q;
            state_q       <= ST_FAULT;
          end
        end
        ST_CHK: begin
          if (!pte_q.v) begin
            fault_o       <= 1'b1;
            fault_cause_o <= CAUSE_PTE_INV;
            fault_adr_o   <= adr_q;
            fault_id_o    <= id_q;
            state_q       <= ST_FAULT;
          end else begin
            tlb_req_q  <= 1'b1;
            tlb_adr_o  <= TLB_LO;
            tlb_dat_o  <= entry_c[63:0];
            upd_busy_o <= 1'b1;
            state_q    <= ST_WR_LO;
          end
        end
        // Strobe low inside a write state is the quiet clock after the ack
        ST_WR_LO, ST_WR_HI, ST_WR_CTL: begin
          if (tlb_req_q) begin
            if (tlb_ack_i) begin
              tlb_req_q <= 1'b0;
            end else if (to_expire_c) begin
              tlb_req_q     <= 1'b0;
              upd_busy_o    <= 1'b0;
              fault_o       <= 1'b1;
              fault_cause_o <= CAUSE_TIMEOUT;
              fault_adr_o   <= adr_q;
              fault_id_o    <= id_q;
              state_q       <= ST_FAULT;
            end
          end else if (state_q == ST_WR_LO) begin
            tlb_req_q <= 1'b1;
            tlb_adr_o <= TLB_HI;
            tlb_dat_o <= entry_c[127:64];
            state_q   <= ST_WR_HI;
          end else if (state_q == ST_WR_HI) begin
            tlb_req_q <= 1'b1;
            tlb_adr_o <= TLB_CTL;
            tlb_dat_o <= ctl_word_c;
            state_q   <= ST_WR_CTL;
          end else begin
            upd_busy_o <= 1'b0;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          way_q   <= (way_q == WAY_W'(WAYS - 1)) ? '0 : way_q + 1'b1;
          state_q <= ST_IDLE;
        end
        ST_FAULT: begin
          if (fault_ack_i) begin
            fault_o       <= 1'b0;
            fault_cause_o <= CAUSE_NONE;
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
